// File: rtl/spi_pkg.sv
// Shared types for the SPI receive-path ping-pong controller.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_SPI = 2'd1,
    ST_SWAP     = 2'd2
  } state_e;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Word counter that stops at a caller-supplied limit; clr has priority over inc.
module sat_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 below
);

  logic [CNT_WIDTH-1:0] cnt_q;

  assign cnt   = cnt_q;
  assign below = (cnt_q < limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && below) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_pingpong_ctrl.sv
// Ping-pong sequencing of two receive buffers between the SPI shifter and the PU.
//   state    | meaning
//   RUN      | SPI fills bank_sel bank, PU drains the other
//   WAIT_SPI | cycle boundary seen mid-transaction; PU re-reads stale frame
//   SWAP     | one-cycle bank exchange, both actions held low
module spi_pingpong_ctrl
  import spi_pkg::*;
#(
  parameter  int BUF_SIZE  = 10,
  localparam int CNT_WIDTH = $clog2(BUF_SIZE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 spi_cs_active,
  input  logic                 spi_word_done,
  input  logic                 spi_xfer_end,
  input  logic                 cycle_begin,
  input  logic                 pu_oe,
  output logic                 bank_sel,
  output logic                 a_receive_mode,
  output logic                 b_receive_mode,
  output logic                 a_action,
  output logic                 b_action,
  output logic [CNT_WIDTH-1:0] frame_len,
  output logic                 stale,
  output logic                 overflow,
  output logic                 underflow
);

  state_e               state_q;
  logic                 bank_sel_q;
  logic                 a_mode_q;
  logic                 b_mode_q;
  logic [CNT_WIDTH-1:0] frame_len_q;
  logic                 stale_q;
  logic                 overflow_q;
  logic                 underflow_q;

  logic [CNT_WIDTH-1:0] spi_cnt;
  logic [CNT_WIDTH-1:0] pu_cnt;
  logic                 spi_below;
  logic                 pu_below;
  logic                 in_swap;
  logic                 spi_fwd;
  logic                 pu_fwd;
  logic                 swap_go;

  assign in_swap = (state_q == ST_SWAP);
  assign spi_fwd = spi_word_done && spi_below && !in_swap;
  assign pu_fwd  = pu_oe && pu_below && !in_swap;

  always_comb begin
    swap_go = 1'b0;
    unique case (state_q)
      ST_RUN:      swap_go = cycle_begin && (!spi_cs_active || spi_xfer_end);
      ST_WAIT_SPI: swap_go = spi_xfer_end || !spi_cs_active;
      default:     swap_go = 1'b0;
    endcase
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_spi_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (spi_fwd),
    .clr   (swap_go),
    .limit (CNT_WIDTH'(BUF_SIZE)),
    .cnt   (spi_cnt),
    .below (spi_below)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_pu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pu_fwd),
    .clr   (swap_go),
    .limit (frame_len_q),
    .cnt   (pu_cnt),
    .below (pu_below)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      bank_sel_q  <= BANK_A;
      a_mode_q    <= 1'b1;
      b_mode_q    <= 1'b0;
      frame_len_q <= '0;
      stale_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (spi_word_done && !spi_fwd) overflow_q  <= 1'b1;
      if (pu_oe && !pu_fwd)          underflow_q <= 1'b1;
      if (swap_go) begin
        // A word landing in the same cycle as the boundary belongs to the outgoing frame.
        state_q     <= ST_SWAP;
        bank_sel_q  <= ~bank_sel_q;
        a_mode_q    <= bank_sel_q;
        b_mode_q    <= ~bank_sel_q;
        frame_len_q <= spi_cnt + CNT_WIDTH'(spi_fwd);
        stale_q     <= 1'b0;
      end else begin
        unique case (state_q)
          ST_RUN: begin
            if (cycle_begin && spi_cs_active) begin
              state_q <= ST_WAIT_SPI;
              stale_q <= 1'b1;
            end
          end
          ST_WAIT_SPI: state_q <= ST_WAIT_SPI;
          default:     state_q <= ST_RUN;
        endcase
      end
    end
  end

  assign bank_sel       = bank_sel_q;
  assign a_receive_mode = a_mode_q;
  assign b_receive_mode = b_mode_q;
  assign a_action       = (bank_sel_q == BANK_A) ? spi_fwd : pu_fwd;
  assign b_action       = (bank_sel_q == BANK_B) ? spi_fwd : pu_fwd;
  assign frame_len      = frame_len_q;
  assign stale          = stale_q;
  assign overflow       = overflow_q;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_spi_pingpong_ctrl.sv
// Scoreboard bench: frame-level model predicts every cycle's outputs, monitor compares at negedge.
module tb_spi_pingpong_ctrl;

  localparam int BUF_SIZE = 10;
  localparam int CW       = $clog2(BUF_SIZE + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_cs_active = 1'b0, spi_word_done = 1'b0, spi_xfer_end = 1'b0;
  logic cycle_begin = 1'b0, pu_oe = 1'b0;
  logic bank_sel, a_receive_mode, b_receive_mode, a_action, b_action;
  logic [CW-1:0] frame_len;
  logic stale, overflow, underflow;

  always #5 clk = ~clk;

  spi_pingpong_ctrl #(.BUF_SIZE(BUF_SIZE)) dut (
    .clk            (clk),
    .rst            (rst),
    .spi_cs_active  (spi_cs_active),
    .spi_word_done  (spi_word_done),
    .spi_xfer_end   (spi_xfer_end),
    .cycle_begin    (cycle_begin),
    .pu_oe          (pu_oe),
    .bank_sel       (bank_sel),
    .a_receive_mode (a_receive_mode),
    .b_receive_mode (b_receive_mode),
    .a_action       (a_action),
    .b_action       (b_action),
    .frame_len      (frame_len),
    .stale          (stale),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  typedef struct packed {
    logic          bsel;
    logic          amode;
    logic          bmode;
    logic          aact;
    logic          bact;
    logic [CW-1:0] flen;
    logic          stl;
    logic          ovf;
    logic          unf;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Reference model: the frame being filled, the frame being read, and whether a handover is pending.
  bit m_known = 0;
  int m_owner;        // bank index the SPI side is writing (0=A, 1=B)
  int m_fill;         // words accepted into the filling frame
  int m_read;         // words consumed from the published frame
  int m_pub;          // length of the published frame
  bit m_pending;      // boundary seen, waiting for the transaction to finish
  bit m_handover;     // the single exchange cycle
  bit m_ovf, m_unf;

  task automatic model_reset();
    m_owner = 0; m_fill = 0; m_read = 0; m_pub = 0;
    m_pending = 0; m_handover = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic cyc(input bit r, input bit cs, input bit wd, input bit xe,
                     input bit cb, input bit oe);
    bit   w_ok, r_ok, go;
    obs_t e;
    @(posedge clk);
    #1;
    rst = r; spi_cs_active = cs; spi_word_done = wd;
    spi_xfer_end = xe; cycle_begin = cb; pu_oe = oe;
    cyc_n++;
    w_ok = wd && !m_handover && (m_fill < BUF_SIZE);
    r_ok = oe && !m_handover && (m_read < m_pub);
    if (m_known) begin
      e.bsel  = m_owner[0];
      e.amode = (m_owner == 0);
      e.bmode = (m_owner == 1);
      e.aact  = (m_owner == 0) ? w_ok : r_ok;
      e.bact  = (m_owner == 1) ? w_ok : r_ok;
      e.flen  = CW'(m_pub);
      e.stl   = m_pending;
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      exp_q.push_back(e);
    end
    if (r) begin
      model_reset();
      m_known = 1;
    end else begin
      if (wd && !w_ok) m_ovf = 1;
      if (oe && !r_ok) m_unf = 1;
      m_fill += int'(w_ok);
      m_read += int'(r_ok);
      go = !m_handover &&
           (m_pending ? (xe || !cs) : (cb && (!cs || xe)));
      if (go) begin
        m_owner = 1 - m_owner;
        m_pub = m_fill; m_fill = 0; m_read = 0;
        m_pending = 0; m_handover = 1;
      end else begin
        if (!m_handover && !m_pending && cb && cs) m_pending = 1;
        m_handover = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    obs_t g, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {bank_sel, a_receive_mode, b_receive_mode, a_action, b_action,
           frame_len, stale, overflow, underflow};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL outputs t=%0t: got bsel=%b am=%b bm=%b aa=%b ba=%b flen=%0d stale=%b ovf=%b unf=%b required bsel=%b am=%b bm=%b aa=%b ba=%b flen=%0d stale=%b ovf=%b unf=%b",
                 $time, g.bsel, g.amode, g.bmode, g.aact, g.bact, g.flen, g.stl, g.ovf, g.unf,
                 e.bsel, e.amode, e.bmode, e.aact, e.bact, e.flen, e.stl, e.ovf, e.unf);
      end
    end
  end

  initial begin
    bit cs_r;
    int guard;
    // reset, 3 words, end of transfer, boundary -> swap
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    // 3 reads forwarded, 4th underflows
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    // boundary mid-transaction: stale until transfer end
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 0, 1);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 1, 0, 0);
    idle(2);
    // overfill: 12 words into 10-word bank
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 11; i++) cyc(0, 0, 0, 0, 0, 1);
    // boundary and transfer end together
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 1, 0);
    idle(2);
    // reset while waiting with 4 words in the SPI bank
    for (int i = 0; i < 2; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    idle(3);
    // randomized traffic
    cs_r = 0;
    for (int i = 0; i < 4000; i++) begin
      bit cs_n, wd, xe, cb, oe, r;
      cs_n = ($urandom_range(0, 9) == 0) ? !cs_r : cs_r;
      xe   = (cs_r && !cs_n) || ($urandom_range(0, 99) == 0);
      wd   = cs_n ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      cb   = ($urandom_range(0, 14) == 0);
      oe   = ($urandom_range(0, 9) < 3);
      r    = ($urandom_range(0, 299) == 0);
      cyc(r, cs_n, wd, xe, cb, oe);
      cs_r = cs_n;
    end
    idle(1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
